// File: rtl/fetch_grant_sequencer.sv
// fetch_grant_sequencer
//   Queues up to two grants per cycle from the two-grant resolver and feeds
//   the head warp to the I-cache. The queue is a circular FIFO of
//   {warp_id, live} entries. A branch redirect (Flush_PC) kills that warp's
//   queued entry in place. Dead entries at the head are silently discarded.
//
//   Optional feature macro: FETCH_SEQ_PERF_EN adds saturating performance
//   counters Perf_Fetch_Cnt / Perf_Drop_Cnt.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   GRT_1, GRT_2   [7:0]     one-hot/zero grants; GRT_1 is ordered first
//   Flush_PC       [7:0]     per-warp kill of queued entries
//   ICache_Ready             I-cache accepts the head this cycle
//   Fetch_Valid, Fetch_WarpID  head entry presented to the I-cache
//   Pending_PC     [7:0]     warp has a live queued entry
//   Queue_Full               fewer than two free slots
//   Queue_Count              occupied entries, killed entries included
//   Drop_Err                 sticky, a grant was lost to overflow
module fetch_grant_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               GRT_1,
  input  logic [7:0]               GRT_2,
  input  logic [7:0]               Flush_PC,
  input  logic                     ICache_Ready,
  output logic                     Fetch_Valid,
  output logic [2:0]               Fetch_WarpID,
  output logic [7:0]               Pending_PC,
  output logic                     Queue_Full,
  output logic [$clog2(DEPTH):0]   Queue_Count,
  output logic                     Drop_Err
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [15:0]              Perf_Fetch_Cnt,
  output logic [15:0]              Perf_Drop_Cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [2:0] warp_id;
    logic       live;
  } entry_t;

  entry_t        q [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;

  function automatic logic [2:0] oh2id(input logic [7:0] oh);
    oh2id = 3'd0;
    for (int i = 0; i < 8; i++)
      if (oh[i]) oh2id = 3'(i);
  endfunction

  // Outputs depend on registers only.
  assign Fetch_Valid  = (count != '0) && q[head].live;
  assign Fetch_WarpID = q[head].warp_id;
  assign Queue_Count  = count;
  assign Queue_Full   = count > CW'(DEPTH - 2);

  logic [7:0]  pend_eff, push_mask, pop_mask;
  logic        c1, c2, p1, p2, pop, fpop;
  logic [CW:0] free;
  logic [1:0]  n_push, n_drop;
  logic [2:0]  id_a, id_b;

  always_comb begin
    // A flush in the same cycle frees the warp before its grant is judged.
    pend_eff  = Pending_PC & ~Flush_PC;
    c1        = (GRT_1 != 8'h0) && ((GRT_1 & pend_eff) == 8'h0);
    c2        = (GRT_2 != 8'h0) && (GRT_2 != GRT_1) && ((GRT_2 & pend_eff) == 8'h0);
    fpop      = Fetch_Valid && ICache_Ready;
    // Dead heads drain without waiting for the I-cache.
    pop       = (count != '0) && (!q[head].live || ICache_Ready);
    free      = (CW+1)'(DEPTH) - (CW+1)'(count) + (CW+1)'(pop);
    p1        = c1 && (free != '0);
    p2        = c2 && (free > (CW+1)'(p1));
    n_push    = 2'(p1) + 2'(p2);
    n_drop    = 2'(c1 && !p1) + 2'(c2 && !p2);
    id_a      = p1 ? oh2id(GRT_1) : oh2id(GRT_2);
    id_b      = oh2id(GRT_2);
    push_mask = (p1 ? GRT_1 : 8'h0) | (p2 ? GRT_2 : 8'h0);
    // Only a live pop clears pending; a dead entry's warp was already
    // cleared by its flush and may own a newer live entry by now.
    pop_mask  = fpop ? (8'h01 << Fetch_WarpID) : 8'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      Pending_PC <= 8'h0;
      Drop_Err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (Flush_PC[q[i].warp_id]) q[i].live <= 1'b0;
      // New entries are written after the kill so they land live.
      if (n_push != 2'd0) q[tail] <= '{warp_id: id_a, live: 1'b1};
      if (n_push == 2'd2) q[tail + PW'(1)] <= '{warp_id: id_b, live: 1'b1};
      head       <= head + PW'(pop);
      tail       <= tail + PW'(n_push);
      count      <= count + CW'(n_push) - CW'(pop);
      Pending_PC <= (Pending_PC & ~Flush_PC & ~pop_mask) | push_mask;
      if (n_drop != 2'd0) Drop_Err <= 1'b1;
    end
  end

`ifdef FETCH_SEQ_PERF_EN
  logic [16:0] drop_sum;
  assign drop_sum = {1'b0, Perf_Drop_Cnt} + 17'(n_drop);

  always_ff @(posedge clk) begin
    if (rst) begin
      Perf_Fetch_Cnt <= 16'h0;
      Perf_Drop_Cnt  <= 16'h0;
    end else begin
      if (fpop && Perf_Fetch_Cnt != 16'hFFFF) Perf_Fetch_Cnt <= Perf_Fetch_Cnt + 16'h1;
      Perf_Drop_Cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_fetch_grant_sequencer.sv
module tb_fetch_grant_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] GRT_1, GRT_2, Flush_PC;
  logic       ICache_Ready;
  logic       Fetch_Valid;
  logic [2:0] Fetch_WarpID;
  logic [7:0] Pending_PC;
  logic       Queue_Full;
  logic [2:0] Queue_Count;
  logic       Drop_Err;
`ifdef FETCH_SEQ_PERF_EN
  logic [15:0] Perf_Fetch_Cnt, Perf_Drop_Cnt;
`endif

  int ncmp = 0;
  int nerr = 0;

  fetch_grant_sequencer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .GRT_1(GRT_1), .GRT_2(GRT_2), .Flush_PC(Flush_PC),
    .ICache_Ready(ICache_Ready), .Fetch_Valid(Fetch_Valid), .Fetch_WarpID(Fetch_WarpID),
    .Pending_PC(Pending_PC), .Queue_Full(Queue_Full), .Queue_Count(Queue_Count),
    .Drop_Err(Drop_Err)
`ifdef FETCH_SEQ_PERF_EN
    , .Perf_Fetch_Cnt(Perf_Fetch_Cnt), .Perf_Drop_Cnt(Perf_Drop_Cnt)
`endif
  );

  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    GRT_1 = 8'h0; GRT_2 = 8'h0; Flush_PC = 8'h0;
  endtask

  task automatic do_reset();
    idle(); ICache_Ready = 1'b0; rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    ncmp++; if (Fetch_Valid !== 1'b0)  begin nerr++; $display("FAIL rst_fv: got %b want 0", Fetch_Valid); end
    ncmp++; if (Fetch_WarpID !== 3'd0) begin nerr++; $display("FAIL rst_id: got %0d want 0", Fetch_WarpID); end
    ncmp++; if (Pending_PC !== 8'h00)  begin nerr++; $display("FAIL rst_pend: got %h want 00", Pending_PC); end
    ncmp++; if (Queue_Full !== 1'b0)   begin nerr++; $display("FAIL rst_full: got %b want 0", Queue_Full); end
    ncmp++; if (Queue_Count !== 3'd0)  begin nerr++; $display("FAIL rst_cnt: got %0d want 0", Queue_Count); end
    ncmp++; if (Drop_Err !== 1'b0)     begin nerr++; $display("FAIL rst_drop: got %b want 0", Drop_Err); end
  endtask

  task automatic test_two_grants();
    do_reset();
    ICache_Ready = 1'b1; GRT_1 = 8'h08; GRT_2 = 8'h04;
    step(); idle();
    ncmp++; if ({Fetch_Valid, Fetch_WarpID} !== 4'b1_011) begin nerr++; $display("FAIL tg_head1: got %b/%0d want 1/3", Fetch_Valid, Fetch_WarpID); end
    ncmp++; if (Pending_PC !== 8'h0C) begin nerr++; $display("FAIL tg_pend1: got %h want 0C", Pending_PC); end
    ncmp++; if (Queue_Count !== 3'd2) begin nerr++; $display("FAIL tg_cnt1: got %0d want 2", Queue_Count); end
    step();
    ncmp++; if ({Fetch_Valid, Fetch_WarpID} !== 4'b1_010) begin nerr++; $display("FAIL tg_head2: got %b/%0d want 1/2", Fetch_Valid, Fetch_WarpID); end
    ncmp++; if (Pending_PC !== 8'h04) begin nerr++; $display("FAIL tg_pend2: got %h want 04", Pending_PC); end
    step();
    ncmp++; if (Fetch_Valid !== 1'b0) begin nerr++; $display("FAIL tg_fv3: got %b want 0", Fetch_Valid); end
    ncmp++; if (Pending_PC !== 8'h00) begin nerr++; $display("FAIL tg_pend3: got %h want 00", Pending_PC); end
  endtask

  task automatic test_fill_drop();
    logic [2:0] exp_id;
    do_reset();
    GRT_1 = 8'h01; GRT_2 = 8'h02; step();
    ncmp++; if ({Queue_Count, Queue_Full} !== 4'b010_0) begin nerr++; $display("FAIL fd_cnt2: got %0d/%b want 2/0", Queue_Count, Queue_Full); end
    GRT_1 = 8'h04; GRT_2 = 8'h00; step();
    ncmp++; if ({Queue_Count, Queue_Full} !== 4'b011_1) begin nerr++; $display("FAIL fd_cnt3: got %0d/%b want 3/1", Queue_Count, Queue_Full); end
    GRT_1 = 8'h08; step();
    ncmp++; if ({Queue_Count, Drop_Err} !== 4'b100_0) begin nerr++; $display("FAIL fd_cnt4: got %0d/%b want 4/0", Queue_Count, Drop_Err); end
    ncmp++; if ({Fetch_Valid, Fetch_WarpID} !== 4'b1_000) begin nerr++; $display("FAIL fd_hold: got %b/%0d want 1/0", Fetch_Valid, Fetch_WarpID); end
    GRT_1 = 8'h10; step();
    ncmp++; if ({Queue_Count, Drop_Err} !== 4'b100_1) begin nerr++; $display("FAIL fd_drop: got %0d/%b want 4/1", Queue_Count, Drop_Err); end
    ncmp++; if (Pending_PC !== 8'h0F) begin nerr++; $display("FAIL fd_pend: got %h want 0F", Pending_PC); end
    idle(); ICache_Ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_id = 3'(k);
      ncmp++; if ({Fetch_Valid, Fetch_WarpID} !== {1'b1, exp_id}) begin nerr++; $display("FAIL fd_drain%0d: got %b/%0d want 1/%0d", k, Fetch_Valid, Fetch_WarpID, exp_id); end
      step();
    end
    ncmp++; if ({Queue_Count, Fetch_Valid, Drop_Err} !== 5'b000_0_1) begin nerr++; $display("FAIL fd_empty: got %0d/%b/%b want 0/0/1", Queue_Count, Fetch_Valid, Drop_Err); end
  endtask

  task automatic test_full_pop_push();
    do_reset();
    GRT_1 = 8'h01; GRT_2 = 8'h02; step();
    GRT_1 = 8'h04; GRT_2 = 8'h08; step();
    ncmp++; if ({Queue_Count, Queue_Full} !== 4'b100_1) begin nerr++; $display("FAIL fp_full: got %0d/%b want 4/1", Queue_Count, Queue_Full); end
    ICache_Ready = 1'b1; GRT_1 = 8'h10; GRT_2 = 8'h00; step(); idle(); ICache_Ready = 1'b0;
    ncmp++; if ({Queue_Count, Drop_Err} !== 4'b100_0) begin nerr++; $display("FAIL fp_cnt: got %0d/%b want 4/0", Queue_Count, Drop_Err); end
    ncmp++; if ({Fetch_Valid, Fetch_WarpID} !== 4'b1_001) begin nerr++; $display("FAIL fp_head: got %b/%0d want 1/1", Fetch_Valid, Fetch_WarpID); end
    ncmp++; if (Pending_PC !== 8'h1E) begin nerr++; $display("FAIL fp_pend: got %h want 1E", Pending_PC); end
  endtask

  task automatic test_flush();
    do_reset();
    GRT_1 = 8'h02; GRT_2 = 8'h20; step(); idle();
    ncmp++; if (Pending_PC !== 8'h22) begin nerr++; $display("FAIL fl_pend0: got %h want 22", Pending_PC); end
    Flush_PC = 8'h20; step(); Flush_PC = 8'h00;
    ncmp++; if (Pending_PC !== 8'h02) begin nerr++; $display("FAIL fl_pend1: got %h want 02", Pending_PC); end
    ncmp++; if ({Fetch_Valid, Fetch_WarpID, Queue_Count} !== 7'b1_001_010) begin nerr++; $display("FAIL fl_head: got %b/%0d/%0d want 1/1/2", Fetch_Valid, Fetch_WarpID, Queue_Count); end
    ICache_Ready = 1'b1; step();
    ncmp++; if ({Fetch_Valid, Queue_Count} !== 4'b0_001) begin nerr++; $display("FAIL fl_dead: got %b/%0d want 0/1", Fetch_Valid, Queue_Count); end
    step();
    ncmp++; if ({Fetch_Valid, Queue_Count, Pending_PC} !== 12'b0_000_00000000) begin nerr++; $display("FAIL fl_gone: got %b/%0d/%h want 0/0/00", Fetch_Valid, Queue_Count, Pending_PC); end
  endtask

  task automatic test_same_grant();
    do_reset();
    GRT_1 = 8'h01; GRT_2 = 8'h01; step();
    ncmp++; if ({Queue_Count, Pending_PC} !== 11'b001_00000001) begin nerr++; $display("FAIL sg_push: got %0d/%h want 1/01", Queue_Count, Pending_PC); end
    step(); idle();
    ncmp++; if ({Queue_Count, Drop_Err} !== 4'b001_0) begin nerr++; $display("FAIL sg_repeat: got %0d/%b want 1/0", Queue_Count, Drop_Err); end
    // Flush and re-grant the same warp together: old entry dies, new one lives.
    Flush_PC = 8'h01; GRT_1 = 8'h01; step(); idle();
    ncmp++; if ({Queue_Count, Pending_PC, Fetch_Valid} !== 12'b010_00000001_0) begin nerr++; $display("FAIL sg_flgrt: got %0d/%h/%b want 2/01/0", Queue_Count, Pending_PC, Fetch_Valid); end
    ICache_Ready = 1'b1; step(); ICache_Ready = 1'b0;
    ncmp++; if ({Queue_Count, Fetch_Valid, Fetch_WarpID, Pending_PC} !== 15'b001_1_000_00000001) begin nerr++; $display("FAIL sg_live: got %0d/%b/%0d/%h want 1/1/0/01", Queue_Count, Fetch_Valid, Fetch_WarpID, Pending_PC); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    GRT_1 = 8'h40; GRT_2 = 8'h80; step();
    GRT_1 = 8'h20; GRT_2 = 8'h00; step();
    ncmp++; if (Queue_Count !== 3'd3) begin nerr++; $display("FAIL rm_pre: got %0d want 3", Queue_Count); end
    rst = 1'b1; ICache_Ready = 1'b1; GRT_1 = 8'h01; Flush_PC = 8'h40; step();
    rst = 1'b0; idle();
    ncmp++; if ({Fetch_Valid, Fetch_WarpID, Pending_PC, Queue_Full, Queue_Count, Drop_Err} !== 17'b0) begin nerr++; $display("FAIL rm_zero: got %b/%0d/%h/%b/%0d/%b want all 0", Fetch_Valid, Fetch_WarpID, Pending_PC, Queue_Full, Queue_Count, Drop_Err); end
    step();
    ncmp++; if (Fetch_Valid !== 1'b0) begin nerr++; $display("FAIL rm_nofetch: got %b want 0", Fetch_Valid); end
  endtask

`ifdef FETCH_SEQ_PERF_EN
  task automatic test_perf();
    do_reset();
    ICache_Ready = 1'b1;
    for (int k = 0; k < 70002; k++) begin
      GRT_1 = k[0] ? 8'h02 : 8'h01;
      step();
    end
    idle(); step();
    ncmp++; if (Perf_Fetch_Cnt !== 16'hFFFF) begin nerr++; $display("FAIL pf_fetch: got %h want FFFF", Perf_Fetch_Cnt); end
    ncmp++; if (Perf_Drop_Cnt !== 16'h0000) begin nerr++; $display("FAIL pf_drop: got %h want 0000", Perf_Drop_Cnt); end
  endtask
`endif

  initial begin
    rst = 1'b1; ICache_Ready = 1'b0; idle();
    test_reset();
    test_two_grants();
    test_fill_drop();
    test_full_pop_push();
    test_flush();
    test_same_grant();
    test_reset_midflight();
`ifdef FETCH_SEQ_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
